// File: rtl/screen_scan.sv
// screen_scan: responder end of the draw-primitive screen interface.
//
// Accepts a rectangle request from a draw engine and walks it in raster order
// (x inner, y outer). Each pixel takes two cycles:
//   READ  - the pixel coordinate and framebuffer read address are presented.
//   WRITE - the framebuffer colour (1-cycle RAM latency) is shown to the initiator
//           as old_screen_colour. The initiator's combinational new_screen_colour
//           is written back to the framebuffer and mirrored to the VGA plot port.
// Pixels outside the visible screen still use their two cycles. They are never
// read or written, and they show colour 0.
//
// Ports:
//   clock, reset         single clock, asynchronous active-low reset
//   screen_start         request strobe, sampled only in IDLE
//   screen_{x,y}_min     rectangle origin
//   screen_{x,y}_range   rectangle size in pixels (0 in either means no pixels)
//   new_screen_colour    colour for the current pixel, combinational from the initiator
//   screen_x, screen_y   current pixel coordinate (READ and WRITE only)
//   old_screen_colour    framebuffer colour at the current pixel (WRITE only)
//   screen_done          one-cycle completion pulse
//   busy                 high from the cycle after acceptance through the DONE cycle
//   fb_rd_addr/fb_rd_data   synchronous-read framebuffer port
//   fb_wr_en/addr/data      framebuffer write port
//   vga_plot/x/y/colour     VGA adapter plot port, a mirror of the framebuffer write

module screen_scan #(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned COLOUR_WIDTH  = 3,
  parameter int unsigned SCREEN_SIZE_X = 160,
  parameter int unsigned SCREEN_SIZE_Y = 120,
  parameter int unsigned ADDR_WIDTH    = 15
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    screen_start,
  input  logic [COLOUR_WIDTH-1:0] new_screen_colour,
  input  logic [WIDTH-1:0]        screen_x_min,
  input  logic [WIDTH-1:0]        screen_y_min,
  input  logic [WIDTH-1:0]        screen_x_range,
  input  logic [WIDTH-1:0]        screen_y_range,
  output logic [WIDTH-1:0]        screen_x,
  output logic [WIDTH-1:0]        screen_y,
  output logic [COLOUR_WIDTH-1:0] old_screen_colour,
  output logic                    screen_done,
  output logic                    busy,
  output logic [ADDR_WIDTH-1:0]   fb_rd_addr,
  input  logic [COLOUR_WIDTH-1:0] fb_rd_data,
  output logic                    fb_wr_en,
  output logic [ADDR_WIDTH-1:0]   fb_wr_addr,
  output logic [COLOUR_WIDTH-1:0] fb_wr_data,
  output logic                    vga_plot,
  output logic [WIDTH-1:0]        vga_x,
  output logic [WIDTH-1:0]        vga_y,
  output logic [COLOUR_WIDTH-1:0] vga_colour
);

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StWrite,
    StDone
  } state_e;

  localparam logic [WIDTH:0] CoordOne = (WIDTH + 1)'(1);

  state_e state_q;

  // The counters carry one extra bit so that a rectangle reaching past 2^WIDTH
  // clips instead of wrapping back onto the visible screen.
  logic [WIDTH:0] cx_q;
  logic [WIDTH:0] cy_q;
  logic [WIDTH:0] x_min_q;
  logic [WIDTH:0] x_last_q;
  logic [WIDTH:0] y_last_q;

  // Coordinates of the last column and row. These only matter when both ranges
  // are non-zero, so the subtraction cannot underflow where it is used.
  logic [WIDTH:0] x_last_in;
  logic [WIDTH:0] y_last_in;

  assign x_last_in = {1'b0, screen_x_min} + {1'b0, screen_x_range} - CoordOne;
  assign y_last_in = {1'b0, screen_y_min} + {1'b0, screen_y_range} - CoordOne;

  logic                  in_bounds;
  logic [ADDR_WIDTH-1:0] pix_addr;

  assign in_bounds = (32'(cx_q) < SCREEN_SIZE_X) && (32'(cy_q) < SCREEN_SIZE_Y);

  // Only used when in_bounds, so the product always fits in ADDR_WIDTH.
  assign pix_addr = ADDR_WIDTH'(cy_q) * ADDR_WIDTH'(SCREEN_SIZE_X) + ADDR_WIDTH'(cx_q);

  // Scan sequencer.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      cx_q     <= '0;
      cy_q     <= '0;
      x_min_q  <= '0;
      x_last_q <= '0;
      y_last_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (screen_start) begin
            x_min_q  <= {1'b0, screen_x_min};
            x_last_q <= x_last_in;
            y_last_q <= y_last_in;
            cx_q     <= {1'b0, screen_x_min};
            cy_q     <= {1'b0, screen_y_min};
            if (screen_x_range == '0 || screen_y_range == '0) begin
              state_q <= StDone;
            end else begin
              state_q <= StRead;
            end
          end
        end
        StRead: begin
          state_q <= StWrite;
        end
        StWrite: begin
          if (cx_q == x_last_q) begin
            if (cy_q == y_last_q) begin
              state_q <= StDone;
            end else begin
              cx_q    <= x_min_q;
              cy_q    <= cy_q + CoordOne;
              state_q <= StRead;
            end
          end else begin
            cx_q    <= cx_q + CoordOne;
            state_q <= StRead;
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  // Output decode. Everything comes from registered state, except the two colour
  // paths. Those pass through so that the RAM read data and the initiator's new
  // colour meet in the same WRITE cycle.
  always_comb begin
    screen_x          = '0;
    screen_y          = '0;
    old_screen_colour = '0;
    fb_rd_addr        = '0;
    fb_wr_en          = 1'b0;
    fb_wr_addr        = '0;
    fb_wr_data        = '0;
    vga_plot          = 1'b0;
    vga_x             = '0;
    vga_y             = '0;
    vga_colour        = '0;
    busy              = (state_q != StIdle);
    screen_done       = (state_q == StDone);

    if (state_q == StRead || state_q == StWrite) begin
      screen_x = cx_q[WIDTH-1:0];
      screen_y = cy_q[WIDTH-1:0];
      if (in_bounds) begin
        fb_rd_addr = pix_addr;
      end
    end

    if (state_q == StWrite && in_bounds) begin
      old_screen_colour = fb_rd_data;
      fb_wr_en          = 1'b1;
      fb_wr_addr        = pix_addr;
      fb_wr_data        = new_screen_colour;
      vga_plot          = 1'b1;
      vga_x             = cx_q[WIDTH-1:0];
      vga_y             = cy_q[WIDTH-1:0];
      vga_colour        = new_screen_colour;
    end
  end

endmodule

// File: tb/tb_screen_scan.sv
// Directed bench for screen_scan with a behavioural synchronous-read framebuffer.
// The start cycle is cycle 0, and outputs are sampled at the falling edge of each later cycle.

module tb_screen_scan;

  localparam int unsigned W  = 8;
  localparam int unsigned CW = 3;
  localparam int unsigned AW = 15;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          screen_start = 1'b0;
  logic [CW-1:0] new_screen_colour;
  logic [W-1:0]  screen_x_min = '0, screen_y_min = '0;
  logic [W-1:0]  screen_x_range = '0, screen_y_range = '0;
  logic [W-1:0]  screen_x, screen_y;
  logic [CW-1:0] old_screen_colour;
  logic          screen_done, busy;
  logic [AW-1:0] fb_rd_addr;
  logic [CW-1:0] fb_rd_data;
  logic          fb_wr_en;
  logic [AW-1:0] fb_wr_addr;
  logic [CW-1:0] fb_wr_data;
  logic          vga_plot;
  logic [W-1:0]  vga_x, vga_y;
  logic [CW-1:0] vga_colour;

  logic [CW-1:0] colour = '0;
  assign new_screen_colour = colour;

  always #5 clock = ~clock;

  screen_scan dut (
    .clock             (clock),
    .reset             (reset),
    .screen_start      (screen_start),
    .new_screen_colour (new_screen_colour),
    .screen_x_min      (screen_x_min),
    .screen_y_min      (screen_y_min),
    .screen_x_range    (screen_x_range),
    .screen_y_range    (screen_y_range),
    .screen_x          (screen_x),
    .screen_y          (screen_y),
    .old_screen_colour (old_screen_colour),
    .screen_done       (screen_done),
    .busy              (busy),
    .fb_rd_addr        (fb_rd_addr),
    .fb_rd_data        (fb_rd_data),
    .fb_wr_en          (fb_wr_en),
    .fb_wr_addr        (fb_wr_addr),
    .fb_wr_data        (fb_wr_data),
    .vga_plot          (vga_plot),
    .vga_x             (vga_x),
    .vga_y             (vga_y),
    .vga_colour        (vga_colour)
  );

  // Framebuffer model: 1-cycle read latency, written on the rising edge.
  logic [CW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clock) begin
    fb_rd_data <= mem[fb_rd_addr];
    if (fb_wr_en) mem[fb_wr_addr] <= fb_wr_data;
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Per-job records.
  int wr_cyc[$];
  int wr_addr[$];
  int wr_data[$];
  int wr_old[$];
  int slot_old[$];
  int done_cyc, done_cnt, busy_low_cyc, plot_cnt, vga_bad;

  function automatic int q_at(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  // Runs one job. Start is held for cycle 0 only. If restart_at > 0, a second
  // start is pulsed in that cycle together with scrambled request inputs.
  task automatic run_job(input int xm, input int ym, input int xr, input int yr,
                         input int col, input int restart_at, input int max_cyc);
    wr_cyc.delete(); wr_addr.delete(); wr_data.delete(); wr_old.delete();
    slot_old.delete();
    done_cyc = -1; done_cnt = 0; busy_low_cyc = -1; plot_cnt = 0; vga_bad = 0;
    @(negedge clock);
    colour         = col[CW-1:0];
    screen_x_min   = xm[W-1:0];
    screen_y_min   = ym[W-1:0];
    screen_x_range = xr[W-1:0];
    screen_y_range = yr[W-1:0];
    screen_start   = 1'b1;
    for (int cyc = 1; cyc <= max_cyc; cyc++) begin
      @(negedge clock);
      screen_start = (cyc == restart_at);
      if (cyc == restart_at) begin
        screen_x_min = 8'd50; screen_y_min = 8'd60;
        screen_x_range = 8'd9; screen_y_range = 8'd9;
      end
      if (fb_wr_en) begin
        wr_cyc.push_back(cyc);
        wr_addr.push_back(int'(fb_wr_addr));
        wr_data.push_back(int'(fb_wr_data));
        wr_old.push_back(int'(old_screen_colour));
      end
      if (vga_plot != fb_wr_en) vga_bad++;
      if (vga_plot) begin
        plot_cnt++;
        if ((int'(vga_y) * 160 + int'(vga_x)) != int'(fb_wr_addr) || vga_colour != fb_wr_data)
          vga_bad++;
      end
      if ((cyc % 2) == 0 && busy && !screen_done) slot_old.push_back(int'(old_screen_colour));
      if (screen_done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
      end
      if (!busy) begin
        busy_low_cyc = cyc;
        break;
      end
    end
    screen_start = 1'b0;
  endtask

  initial begin
    int errs;
    bit seen [0:19199];
    int exp_a [4];
    int exp_c [4];
    int exp_o [4];

    for (int i = 0; i < (1 << AW); i++) mem[i] = CW'(i % 8);

    // Reset state.
    repeat (2) @(negedge clock);
    check("rst busy", busy, 0);
    check("rst done", screen_done, 0);
    check("rst wr_en", fb_wr_en, 0);
    check("rst plot", vga_plot, 0);
    check("rst rd_addr", fb_rd_addr, 0);
    check("rst x", screen_x, 0);
    reset = 1'b1;

    // 2x2 at (2,3).
    run_job(2, 3, 2, 2, 6, 0, 100);
    exp_a = '{482, 483, 642, 643};
    exp_c = '{2, 4, 6, 8};
    exp_o = '{2, 3, 2, 3};
    check("t1 nwr", wr_addr.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t1 addr%0d", i), q_at(wr_addr, i), exp_a[i]);
      check($sformatf("t1 cyc%0d", i), q_at(wr_cyc, i), exp_c[i]);
      check($sformatf("t1 old%0d", i), q_at(wr_old, i), exp_o[i]);
      check($sformatf("t1 data%0d", i), q_at(wr_data, i), 6);
    end
    check("t1 done_cyc", done_cyc, 9);
    check("t1 done_cnt", done_cnt, 1);
    check("t1 busy_low", busy_low_cyc, 10);
    check("t1 plots", plot_cnt, 4);
    check("t1 vga", vga_bad, 0);

    // Empty rectangle.
    run_job(0, 0, 5, 0, 3, 0, 20);
    check("t2 nwr", wr_addr.size(), 0);
    check("t2 plots", plot_cnt, 0);
    check("t2 done_cyc", done_cyc, 1);
    check("t2 busy_low", busy_low_cyc, 2);

    // Clipped 4x4 at the bottom-right corner.
    run_job(158, 118, 4, 4, 4, 0, 100);
    exp_a = '{19038, 19039, 19198, 19199};
    exp_c = '{2, 4, 10, 12};
    exp_o = '{6, 7, 6, 7};
    check("t3 nwr", wr_addr.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t3 addr%0d", i), q_at(wr_addr, i), exp_a[i]);
      check($sformatf("t3 cyc%0d", i), q_at(wr_cyc, i), exp_c[i]);
      check($sformatf("t3 old%0d", i), q_at(wr_old, i), exp_o[i]);
    end
    check("t3 slots", slot_old.size(), 16);
    errs = 0;
    for (int i = 0; i < slot_old.size(); i++)
      if (!(i == 0 || i == 1 || i == 4 || i == 5) && slot_old[i] != 0) errs++;
    check("t3 clipped old", errs, 0);
    check("t3 done_cyc", done_cyc, 33);
    check("t3 vga", vga_bad, 0);

    // Full-screen clear.
    run_job(0, 0, 160, 120, 5, 0, 40000);
    check("t4 nwr", wr_addr.size(), 19200);
    errs = 0;
    for (int i = 0; i < 19200; i++) seen[i] = 1'b0;
    for (int i = 0; i < wr_addr.size(); i++) begin
      if (wr_addr[i] >= 19200 || wr_data[i] != 5) errs++;
      else if (seen[wr_addr[i]]) errs++;
      else seen[wr_addr[i]] = 1'b1;
    end
    check("t4 cover", errs, 0);
    check("t4 done_cyc", done_cyc, 38401);
    check("t4 vga", vga_bad, 0);

    // Second start while busy is ignored.
    run_job(2, 3, 2, 2, 1, 3, 100);
    check("t5 nwr", wr_addr.size(), 4);
    check("t5 addr0", q_at(wr_addr, 0), 482);
    check("t5 addr3", q_at(wr_addr, 3), 643);
    check("t5 old0", q_at(wr_old, 0), 5);
    check("t5 done_cnt", done_cnt, 1);
    check("t5 done_cyc", done_cyc, 9);
    check("t5 busy_low", busy_low_cyc, 10);

    // Back-to-back: start held through DONE. x_min is changed during DONE and
    // must be picked up by the second acceptance.
    @(negedge clock);
    colour = 3'd2;
    screen_x_min = 8'd20; screen_y_min = 8'd0;
    screen_x_range = 8'd1; screen_y_range = 8'd1;
    screen_start = 1'b1;
    repeat (3) @(negedge clock);
    check("b2b done3", screen_done, 1);
    screen_x_min = 8'd30;
    @(negedge clock);
    check("b2b idle4", busy, 0);
    @(negedge clock);
    check("b2b busy5", busy, 1);
    check("b2b x5", screen_x, 30);
    screen_start = 1'b0;
    for (int k = 0; k < 20 && busy; k++) @(negedge clock);
    check("b2b end", busy, 0);

    // Reset in cycle 5 of a 2x2 job.
    @(negedge clock);
    colour = 3'd2;
    screen_x_min = 8'd2; screen_y_min = 8'd3;
    screen_x_range = 8'd2; screen_y_range = 8'd2;
    screen_start = 1'b1;
    @(negedge clock);
    screen_start = 1'b0;
    repeat (4) @(negedge clock);
    check("t6 y5", screen_y, 4);
    check("t6 rd5", fb_rd_addr, 642);
    reset = 1'b0;
    #1;
    check("t6 busy", busy, 0);
    check("t6 x", screen_x, 0);
    check("t6 rd", fb_rd_addr, 0);
    errs = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      if (screen_done || busy) errs++;
    end
    check("t6 quiet", errs, 0);
    check("t6 kept482", mem[482], 2);
    check("t6 kept483", mem[483], 2);
    check("t6 untouched642", mem[642], 1);
    reset = 1'b1;
    run_job(10, 10, 1, 1, 4, 0, 20);
    check("t6 nwr", wr_addr.size(), 1);
    check("t6 addr", q_at(wr_addr, 0), 1610);
    check("t6 cyc", q_at(wr_cyc, 0), 2);
    check("t6 done_cyc", done_cyc, 3);
    check("t6 busy_low", busy_low_cyc, 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/screen_scan.md
Name: screen_scan

Overview:
- Responder end of the draw-primitive screen interface: accepts a rectangle request from a draw engine (clear/triangle via the opcode mux) and scans it in raster order.
- Per pixel it presents (screen_x, screen_y) and the current framebuffer colour, then captures the initiator's combinational new_screen_colour.
- Writes that colour to the framebuffer and mirrors the write to the VGA adapter plot port.
- Sits between the draw dispatcher and the framebuffer RAM / VGA adapter.

Parameters:
- WIDTH, 8, coordinate/range width.
- COLOUR_WIDTH, 3, pixel colour width.
- SCREEN_SIZE_X, 160, visible columns.
- SCREEN_SIZE_Y, 120, visible rows.
- ADDR_WIDTH, 15, framebuffer address width; must satisfy 2^ADDR_WIDTH >= SCREEN_SIZE_X*SCREEN_SIZE_Y.

Ports:
- clock  in  1  single clock.
- reset  in  1  asynchronous, active-low reset.
- screen_start  in  1  request strobe from initiator.
- new_screen_colour  in  COLOUR_WIDTH  colour for the current pixel; combinational from initiator.
- screen_x_min, screen_y_min  in  WIDTH  rectangle origin.
- screen_x_range, screen_y_range  in  WIDTH  rectangle size in pixels (count, not last index).
- screen_x, screen_y  out  WIDTH  current pixel.
- old_screen_colour  out  COLOUR_WIDTH  framebuffer colour at current pixel.
- screen_done  out  1  one-cycle completion pulse.
- busy  out  1  high from the cycle after start acceptance through the DONE cycle.
- fb_rd_addr  out  ADDR_WIDTH  framebuffer read address; synchronous RAM, 1-cycle latency.
- fb_rd_data  in  COLOUR_WIDTH  framebuffer read data.
- fb_wr_en  out  1  framebuffer write enable.
- fb_wr_addr  out  ADDR_WIDTH  framebuffer write address.
- fb_wr_data  out  COLOUR_WIDTH  framebuffer write data.
- vga_plot  out  1  VGA adapter plot strobe.
- vga_x, vga_y  out  WIDTH  VGA adapter plot coordinates.
- vga_colour  out  COLOUR_WIDTH  VGA adapter plot colour.

Behaviour:
- Reset (reset=0, asynchronous): state IDLE. All outputs 0, including screen_done, busy, fb_wr_en and vga_plot. Counters and latched request cleared.
- FSM states: IDLE, READ, WRITE, DONE.
- IDLE:
  - screen_start=1 latches min/range inputs.
  - If either range is 0, go to DONE; otherwise go to READ with cx=x_min, cy=y_min.
  - screen_start is ignored in every other state.
- Counters cx and cy are WIDTH+1 bits; no wrap at 2^WIDTH.
- A pixel is in-bounds when cx<SCREEN_SIZE_X and cy<SCREEN_SIZE_Y.
- READ:
  - screen_x/screen_y = cx/cy truncated to WIDTH bits.
  - fb_rd_addr = cy*SCREEN_SIZE_X+cx when in-bounds, else 0.
  - Next state: WRITE.
- WRITE:
  - screen_x/screen_y and fb_rd_addr held.
  - old_screen_colour = fb_rd_data if in-bounds, else 0.
  - If in-bounds: fb_wr_en=1, fb_wr_addr=same address, fb_wr_data=new_screen_colour, vga_plot=1, vga_x/vga_y/vga_colour equal to the same values.
  - If out-of-bounds: no write and no plot; the cycle is still consumed.
  - Advance in raster order, x inner: cx+1, or cx=x_min and cy+1 at row end.
  - After the last pixel (cx=x_min+x_range-1, cy=y_min+y_range-1), go to DONE; otherwise go to READ.
- DONE: screen_done=1 for exactly one cycle, then IDLE.
- old_screen_colour is 0 outside WRITE. fb_wr_en and vga_plot are 0 outside WRITE.
- Timing: the cycle in which start is accepted is cycle 0.
  - Pixel i is in READ at cycle 2i+1 and in WRITE at cycle 2i+2.
  - For N = x_range*y_range, screen_done is high at cycle 2N+1 and busy falls at cycle 2N+2.
  - For N=0, screen_done is high at cycle 1.
- Back-to-back: a start held high through the DONE cycle is accepted in the next IDLE cycle (cycle 2N+2).
- Input changes to min/range/start while busy have no effect.
- Reset during a scan aborts immediately: no done pulse, and pixels already written stay written.

Test Plan:
- RAM preloaded with addr mod 8. Start (2,3) range 2x2 -> fb writes at addresses 482, 483, 642, 643, in that order, on cycles 2, 4, 6, 8. old_screen_colour = 2, 3, 2, 3. screen_done at cycle 9 only.
- Start with x_range=5, y_range=0 -> no fb writes, no vga_plot; screen_done at cycle 1; busy low at cycle 2.
- Start (158,118) range 4x4 -> 16 pixel slots scanned but only 4 writes, to (158,118), (159,118), (158,119), (159,119). old_screen_colour=0 on clipped slots. screen_done at cycle 33.
- Clear: (0,0) range 160x120, colour 5 -> 19200 writes covering addresses 0..19199 once each, all data 5; screen_done at cycle 38401.
- Second screen_start pulsed at cycle 3 of a 2x2 job -> ignored: exactly 4 writes, one done pulse.
- reset asserted low at cycle 5 of a 2x2 job -> outputs 0 asynchronously, state IDLE, no screen_done. A new start after release runs normally.
